// File: rtl/console_pkg.sv
// Shared definitions for the text console: control-code constants and the
// controller state encoding.
package console_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SCROLL_COPY  = 2'd1,
        SCROLL_BLANK = 2'd2,
        CLEAR        = 2'd3
    } console_state_e;

endpackage

// File: rtl/console_sweeper.sv
// Raster row/col sweeper used for scroll copy, scroll blank and clear.
// Write requests are combinational; the controller registers them onto the plane port.
module console_sweeper
    import console_pkg::*;
#(
    parameter int COLS   = 40,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 6,
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              copy_mode,
    input  logic [ROW_W-1:0]  start_row,
    input  logic [ROW_W-1:0]  end_row,
    input  logic [CHAR_W-1:0] fill_data,
    input  logic [CHAR_W-1:0] rdata,
    output logic [ROW_W-1:0]  rd_row,
    output logic [COL_W-1:0]  rd_col,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic [COL_W-1:0]  wr_col,
    output logic [CHAR_W-1:0] wr_data,
    output logic              done
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic             active_q, active_d, copy_q, copy_d;
    logic             drain_q, drain_d, vld_q, vld_d;
    logic [ROW_W-1:0] row_q, row_d, end_q, end_d, vrow_q, vrow_d, rd_row_q, rd_row_d;
    logic [COL_W-1:0] col_q, col_d, vcol_q, vcol_d, rd_col_q, rd_col_d;
    logic             last_s;

    assign last_s = (row_q == end_q) && (col_q == LAST_COL);

    // Next-state of the sweep counters; in copy mode the read address follows the counters.
    always_comb begin
        active_d = active_q;
        copy_d   = copy_q;
        row_d    = row_q;
        col_d    = col_q;
        end_d    = end_q;
        vrow_d   = vrow_q;
        vcol_d   = vcol_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        vld_d    = 1'b0;
        drain_d  = 1'b0;
        if (start) begin
            active_d = 1'b1;
            copy_d   = copy_mode;
            row_d    = start_row;
            col_d    = '0;
            end_d    = end_row;
            if (copy_mode) begin
                rd_row_d = start_row;
                rd_col_d = '0;
            end else begin
                rd_row_d = rd_row_q;
                rd_col_d = rd_col_q;
            end
        end else if (active_q) begin
            // Remember which source cell is in flight so its data lands one row up.
            vld_d  = copy_q;
            vrow_d = row_q;
            vcol_d = col_q;
            if (last_s) begin
                active_d = 1'b0;
                drain_d  = copy_q;
            end else if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (copy_q) begin
                rd_row_d = row_d;
                rd_col_d = col_d;
            end else begin
                rd_row_d = rd_row_q;
                rd_col_d = rd_col_q;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            copy_q   <= 1'b0;
            drain_q  <= 1'b0;
            vld_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            end_q    <= '0;
            vrow_q   <= '0;
            vcol_q   <= '0;
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            active_q <= active_d;
            copy_q   <= copy_d;
            drain_q  <= drain_d;
            vld_q    <= vld_d;
            row_q    <= row_d;
            col_q    <= col_d;
            end_q    <= end_d;
            vrow_q   <= vrow_d;
            vcol_q   <= vcol_d;
            rd_row_q <= rd_row_d;
            rd_col_q <= rd_col_d;
        end
    end

    assign rd_row  = rd_row_q;
    assign rd_col  = rd_col_q;
    assign wr_en   = copy_q ? vld_q : active_q;
    assign wr_row  = copy_q ? (vrow_q - ROW_W'(1)) : row_q;
    assign wr_col  = copy_q ? vcol_q : col_q;
    assign wr_data = copy_q ? rdata : fill_data;
    assign done    = copy_q ? drain_q : (active_q && last_s);

endmodule

// File: rtl/text_console_ctrl.sv
// Character feeder for the text plane: cursor handling, control codes and
// hardware scroll/clear through the plane's read and write ports.
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int          ROWS       = 15,
    parameter int          COLS       = 40,
    parameter int          CHAR_W     = 8,
    parameter int          ROW_W      = 4,
    parameter int          COL_W      = 6,
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter int          SCROLL_EN  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ROW_W-1:0]  mem_wrow,
    output logic [COL_W-1:0]  mem_wcol,
    output logic [CHAR_W-1:0] mem_wdata,
    output logic [ROW_W-1:0]  mem_rrow,
    output logic [COL_W-1:0]  mem_rcol,
    input  logic [CHAR_W-1:0] mem_rdata,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_CHAR);

    console_state_e    state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, wrow_q, wrow_d;
    logic [COL_W-1:0]  col_q, col_d, wcol_q, wcol_d;
    logic [CHAR_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, ready_q, ready_d, busy_q, busy_d;
    logic              nl_s, printable_s;
    logic              sw_start_s, sw_copy_s, sw_wr_en_s, sw_done_s;
    logic [ROW_W-1:0]  sw_srow_s, sw_erow_s, sw_wr_row_s;
    logic [COL_W-1:0]  sw_wr_col_s;
    logic [CHAR_W-1:0] sw_wr_data_s;

    assign printable_s = (in_char >= CHAR_W'(CH_SPACE)) && (in_char <= CHAR_W'(CH_TILDE));

    console_sweeper #(
        .COLS   (COLS),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .CHAR_W (CHAR_W)
    ) u_sweeper (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (sw_start_s),
        .copy_mode (sw_copy_s),
        .start_row (sw_srow_s),
        .end_row   (sw_erow_s),
        .fill_data (BLANK),
        .rdata     (mem_rdata),
        .rd_row    (mem_rrow),
        .rd_col    (mem_rcol),
        .wr_en     (sw_wr_en_s),
        .wr_row    (sw_wr_row_s),
        .wr_col    (sw_wr_col_s),
        .wr_data   (sw_wr_data_s),
        .done      (sw_done_s)
    );

    // Character interpretation, cursor update and busy-state sequencing.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        we_d       = 1'b0;
        wrow_d     = wrow_q;
        wcol_d     = wcol_q;
        wdata_d    = wdata_q;
        nl_s       = 1'b0;
        sw_start_s = 1'b0;
        sw_copy_s  = 1'b0;
        sw_srow_s  = '0;
        sw_erow_s  = LAST_ROW;
        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    if (printable_s) begin
                        we_d    = 1'b1;
                        wrow_d  = row_q;
                        wcol_d  = col_q;
                        wdata_d = in_char;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            nl_s  = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        case (in_char)
                            CHAR_W'(CH_LF): nl_s = 1'b1;
                            CHAR_W'(CH_CR): col_d = '0;
                            CHAR_W'(CH_BS): begin
                                if (col_q != '0) begin
                                    col_d   = col_q - COL_W'(1);
                                    we_d    = 1'b1;
                                    wrow_d  = row_q;
                                    wcol_d  = col_q - COL_W'(1);
                                    wdata_d = BLANK;
                                end else begin
                                    col_d = col_q;
                                end
                            end
                            CHAR_W'(CH_FF): begin
                                state_d    = CLEAR;
                                row_d      = '0;
                                col_d      = '0;
                                sw_start_s = 1'b1;
                            end
                            default: nl_s = 1'b0;
                        endcase
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            SCROLL_COPY, SCROLL_BLANK, CLEAR: begin
                we_d    = sw_wr_en_s;
                wrow_d  = sw_wr_row_s;
                wcol_d  = sw_wr_col_s;
                wdata_d = sw_wr_data_s;
                if (sw_done_s && (state_q == SCROLL_COPY)) begin
                    state_d    = SCROLL_BLANK;
                    sw_start_s = 1'b1;
                    sw_srow_s  = LAST_ROW;
                end else if (sw_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Newline from the last row either launches a scroll or wraps to the top.
        if (nl_s) begin
            if (row_q != LAST_ROW) begin
                row_d = row_q + ROW_W'(1);
            end else if (SCROLL_EN != 0) begin
                state_d    = SCROLL_COPY;
                col_d      = '0;
                sw_start_s = 1'b1;
                sw_copy_s  = 1'b1;
                sw_srow_s  = ROW_W'(1);
            end else begin
                row_d = '0;
            end
        end else begin
            row_d = row_d;
        end
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // Controller registers; reset leaves the plane contents untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign mem_we     = we_q;
    assign mem_wrow   = wrow_q;
    assign mem_wcol   = wcol_q;
    assign mem_wdata  = wdata_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomised bench for text_console_ctrl against a screen-level reference model
// (4x5 plane with a one-cycle read port).
module tb_text_console_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, v2;
    logic [7:0] in_char, c2;
    logic       in_ready, mem_we, busy;
    logic [2:0] mem_wrow, mem_rrow, cursor_row, mem_wcol, mem_rcol, cursor_col;
    logic [7:0] mem_wdata, mem_rdata;
    logic       in_ready2, mem_we2, busy2;
    logic [2:0] mem_wrow2, mem_rrow2, cursor_row2, mem_wcol2, mem_rcol2, cursor_col2;
    logic [7:0] mem_wdata2;
    logic [7:0] rdata2 = 8'h00;

    logic [7:0] plane   [ROWS][COLS];
    logic [7:0] exp_scr [ROWS][COLS];
    int crow, ccol;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    text_console_ctrl #(.ROWS(ROWS), .COLS(COLS), .CHAR_W(8), .ROW_W(3), .COL_W(3),
                        .BLANK_CHAR(8'h20), .SCROLL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .mem_we(mem_we), .mem_wrow(mem_wrow), .mem_wcol(mem_wcol),
        .mem_wdata(mem_wdata), .mem_rrow(mem_rrow), .mem_rcol(mem_rcol),
        .mem_rdata(mem_rdata), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy));

    text_console_ctrl #(.ROWS(ROWS), .COLS(COLS), .CHAR_W(8), .ROW_W(3), .COL_W(3),
                        .BLANK_CHAR(8'h20), .SCROLL_EN(0)) dut_ns (
        .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_char(c2),
        .in_ready(in_ready2), .mem_we(mem_we2), .mem_wrow(mem_wrow2), .mem_wcol(mem_wcol2),
        .mem_wdata(mem_wdata2), .mem_rrow(mem_rrow2), .mem_rcol(mem_rcol2),
        .mem_rdata(rdata2), .cursor_row(cursor_row2), .cursor_col(cursor_col2),
        .busy(busy2));

    // Character plane: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_we) plane[mem_wrow][mem_wcol] <= mem_wdata;
        mem_rdata <= plane[mem_rrow][mem_rcol];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_newline(output int blen);
        blen = 0;
        if (crow < ROWS - 1) begin
            crow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) exp_scr[r][c] = exp_scr[r+1][c];
            for (int c = 0; c < COLS; c++) exp_scr[ROWS-1][c] = 8'h20;
            ccol = 0;
            blen = (ROWS - 1) * COLS + 1 + COLS;
        end
    endtask

    // Screen-level effect of one accepted character.
    task automatic model_step(input logic [7:0] ch, output bit we, output int wr, output int wc,
                              output logic [7:0] wd, output int blen);
        we = 1'b0; wr = crow; wc = ccol; wd = ch; blen = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            we = 1'b1;
            exp_scr[crow][ccol] = ch;
            ccol++;
            if (ccol == COLS) begin
                ccol = 0;
                model_newline(blen);
            end
        end else if (ch == 8'h0A) begin
            model_newline(blen);
        end else if (ch == 8'h0D) begin
            ccol = 0;
        end else if (ch == 8'h08) begin
            if (ccol > 0) begin
                ccol--;
                we = 1'b1; wc = ccol; wd = 8'h20;
                exp_scr[crow][ccol] = 8'h20;
            end
        end else if (ch == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) exp_scr[r][c] = 8'h20;
            crow = 0; ccol = 0;
            blen = ROWS * COLS;
        end
    endtask

    task automatic compare_plane();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                check($sformatf("plane[%0d][%0d]", r, c), plane[r][c], exp_scr[r][c]);
    endtask

    task automatic send(input logic [7:0] ch);
        bit we, rdy_seen;
        int wr, wc, blen, n;
        logic [7:0] wd;
        check("in_ready", in_ready, 1);
        in_valid = 1'b1; in_char = ch;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_step(ch, we, wr, wc, wd, blen);
        check("cursor_row", cursor_row, crow);
        check("cursor_col", cursor_col, ccol);
        check("mem_we", mem_we, we);
        if (we) begin
            check("mem_wrow", mem_wrow, wr);
            check("mem_wcol", mem_wcol, wc);
            check("mem_wdata", mem_wdata, wd);
        end
        check("busy", busy, blen > 0);
        if (blen > 0) begin
            n = 0; rdy_seen = 1'b0;
            while (busy && n < 200) begin
                n++;
                rdy_seen |= in_ready;
                @(posedge clk); #1;
            end
            check("busy_len", n, blen);
            check("ready_low", rdy_seen, 0);
            @(posedge clk); #1;
            compare_plane();
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                plane[r][c] = 8'h2E;
                exp_scr[r][c] = 8'h2E;
            end
        crow = 0; ccol = 0;
        reset_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; v2 = 1'b0; c2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_row", cursor_row, 0);
        check("rst_col", cursor_col, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1);
        check("ready2_after_rst", in_ready2, 1);

        // No-scroll variant: newlines wrap to row 0 without memory traffic.
        for (int i = 0; i < 4; i++) begin
            v2 = 1'b1; c2 = 8'h0A;
            @(posedge clk); #1;
            check("ns_row", cursor_row2, (i + 1) % ROWS);
            check("ns_we", mem_we2, 0);
            check("ns_ready", in_ready2, 1);
        end
        v2 = 1'b0;

        // Directed walk through the basic feeder behaviour and one scroll.
        send(8'h41);
        send(8'h42);
        send(8'h08);
        send(8'h0D);
        send(8'h08);
        for (int i = 0; i < 20; i++) send(8'h61 + 8'(i));
        check("rrow_hold", mem_rrow, ROWS - 1);
        check("rcol_hold", mem_rcol, COLS - 1);
        send(8'h0C);

        // Reset five cycles into a scroll aborts at once.
        send(8'h0A); send(8'h0A); send(8'h0A);
        in_valid = 1'b1; in_char = 8'h0A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("scroll_busy", busy, 1);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_row", cursor_row, 0);
        check("abort_col", cursor_col, 0);
        check("abort_ready", in_ready, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_up", in_ready, 1);
        crow = 0; ccol = 0;
        send(8'h0C);

        // Random character stream.
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [7:0] ch;
            sel = $urandom_range(0, 99);
            if (sel < 60)      ch = 8'($urandom_range(32, 126));
            else if (sel < 70) ch = 8'h0A;
            else if (sel < 78) ch = 8'h0D;
            else if (sel < 88) ch = 8'h08;
            else if (sel < 90) ch = 8'h0C;
            else               ch = 8'($urandom_range(0, 255));
            send(ch);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        compare_plane();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
